instr2cache_bridge: RTL and testbench

- Parametrised successor of the core-instruction/I$ request/response converter; sits between the core instruction fetch port and the tile instruction cache.
- Adds real grant backpressure and up to MaxOutstanding in-flight fetches.
- Selects the requested word out of a line-wide cache response, using per-request offsets kept in an in-order FIFO.
- Adds a flush that discards responses to fetches issued before it, plus a registered response stage.

---
 rtl/redmule_tile_pkg.sv | 40 ++++
 rtl/fifo_v3.sv | 60 ++++++
 rtl/instr2cache_bridge.sv | 132 +++++++++++++
 tb/tb_instr2cache_bridge.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/redmule_tile_pkg.sv
// Shared tile definitions: default fetch/cache widths, flat request/response
// groups so wrappers can pack bridge ports into struct types, and a width helper.
package redmule_tile_pkg;

  localparam int unsigned InstrAddrWidth = 32;
  localparam int unsigned InstrDataWidth = 32;
  localparam int unsigned CacheLineWidth = 128;

  typedef struct packed {
    logic                      req;
    logic [InstrAddrWidth-1:0] addr;
    logic [1:0]                memtype;
  } instr_req_t;

  typedef struct packed {
    logic                      gnt;
    logic                      rvalid;
    logic [InstrDataWidth-1:0] rdata;
    logic                      err;
  } instr_rsp_t;

  typedef struct packed {
    logic                      valid;
    logic [InstrAddrWidth-1:0] addr;
    logic                      cacheable;
  } cache_req_t;

  typedef struct packed {
    logic                      valid;
    logic [CacheLineWidth-1:0] data;
    logic                      error;
  } cache_rsp_t;

  // Number of address bits selecting a word inside a cache line.
  function automatic int unsigned word_offset_width(input int unsigned line_w,
                                                    input int unsigned data_w);
    return $clog2(line_w / data_w);
  endfunction

endpackage

// File: rtl/fifo_v3.sv
// In-order FIFO with optional fall-through.
// Ports: clk_i/rst_ni clock and async active-low reset, flush_i clears content,
// full_o/empty_o status, data_i/push_i write side, data_o/pop_i read side.
module fifo_v3 #(
  parameter bit          FALL_THROUGH = 1'b0,
  parameter int unsigned DATA_WIDTH   = 32,
  parameter int unsigned DEPTH        = 8
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  flush_i,
  output logic                  full_o,
  output logic                  empty_o,
  input  logic [DATA_WIDTH-1:0] data_i,
  input  logic                  push_i,
  output logic [DATA_WIDTH-1:0] data_o,
  input  logic                  pop_i
);

  localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned UseW = $clog2(DEPTH + 1);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [PtrW-1:0]       rd_q, wr_q;
  logic [UseW-1:0]       usage_q;
  logic                  do_push, do_pop, bypass;

  assign full_o  = (usage_q == UseW'(DEPTH));
  assign empty_o = (usage_q == '0);

  // A fall-through push popped in the same cycle never lands in storage.
  assign bypass  = FALL_THROUGH && empty_o && push_i && pop_i;
  assign do_push = push_i && !full_o && !bypass;
  assign do_pop  = pop_i && !empty_o;
  assign data_o  = (FALL_THROUGH && empty_o) ? data_i : mem_q[rd_q];

  // Pointer and occupancy update.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rd_q    <= '0;
      wr_q    <= '0;
      usage_q <= '0;
      for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
    end else if (flush_i) begin
      rd_q    <= '0;
      wr_q    <= '0;
      usage_q <= '0;
    end else begin
      if (do_push) begin
        mem_q[wr_q] <= data_i;
        wr_q        <= (wr_q == PtrW'(DEPTH - 1)) ? '0 : wr_q + PtrW'(1);
      end
      if (do_pop) begin
        rd_q <= (rd_q == PtrW'(DEPTH - 1)) ? '0 : rd_q + PtrW'(1);
      end
      usage_q <= usage_q + UseW'(do_push) - UseW'(do_pop);
    end
  end

endmodule

// File: rtl/instr2cache_bridge.sv
// Core instruction fetch port to tile instruction cache bridge.
// Grants fetches under cache backpressure with up to MaxOutstanding in flight,
// selects the requested word from line-wide responses, and supports flushing
// responses of fetches issued before the flush.
// Ports: clk_i/rst_ni clock and async active-low reset; flush_i drop pulse;
// instr_* core fetch request/response; cache_* cache request/response;
// spurious_o sticky flag for responses arriving with nothing outstanding.
module instr2cache_bridge
  import redmule_tile_pkg::*;
#(
  parameter int unsigned AddrWidth      = InstrAddrWidth,
  parameter int unsigned DataWidth      = InstrDataWidth,
  parameter int unsigned LineWidth      = CacheLineWidth,
  parameter int unsigned MaxOutstanding = 2
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 flush_i,
  input  logic                 instr_req_i,
  input  logic [AddrWidth-1:0] instr_addr_i,
  input  logic [1:0]           instr_memtype_i,
  output logic                 instr_gnt_o,
  output logic                 instr_rvalid_o,
  output logic [DataWidth-1:0] instr_rdata_o,
  output logic                 instr_err_o,
  output logic                 cache_valid_o,
  input  logic                 cache_ready_i,
  output logic [AddrWidth-1:0] cache_addr_o,
  output logic                 cache_cacheable_o,
  input  logic                 cache_rsp_valid_i,
  input  logic [LineWidth-1:0] cache_rsp_data_i,
  input  logic                 cache_rsp_error_i,
  output logic                 spurious_o
);

  localparam int unsigned OffW  = word_offset_width(LineWidth, DataWidth);
  localparam int unsigned FifoW = (OffW > 0) ? OffW : 1;
  localparam int unsigned CntW  = $clog2(MaxOutstanding + 1);
  localparam int unsigned Words = LineWidth / DataWidth;
  localparam int unsigned LowW  = OffW + 2;

  logic [CntW-1:0]  cnt_q, cnt_d, drop_q, drop_d;
  logic             not_full, push, pop, deliver, discard;
  logic [FifoW-1:0] fifo_wdata, fifo_rdata;
  logic             fifo_full, fifo_empty;
  logic [Words-1:0][DataWidth-1:0] rsp_words;
  logic [DataWidth-1:0]            rsp_word;
  logic             unused_bits;

  // Request path: grant depends only on the registered count.
  assign not_full          = (cnt_q < CntW'(MaxOutstanding));
  assign cache_valid_o     = instr_req_i && not_full;
  assign instr_gnt_o       = instr_req_i && not_full && cache_ready_i;
  assign cache_addr_o      = {instr_addr_i[AddrWidth-1:LowW], LowW'(0)};
  assign cache_cacheable_o = instr_memtype_i[1];
  assign unused_bits       = ^{instr_memtype_i[0], instr_addr_i[1:0]};

  assign push    = instr_gnt_o;
  assign pop     = cache_rsp_valid_i && (cnt_q != '0);
  assign discard = pop && (drop_q != '0);
  assign deliver = pop && (drop_q == '0);

  assign rsp_words = cache_rsp_data_i;

  // Word select within the line; single-word lines carry a dummy offset.
  if (OffW > 0) begin : g_off
    assign fifo_wdata = instr_addr_i[OffW+1:2];
    assign rsp_word   = rsp_words[fifo_rdata];
  end else begin : g_no_off
    assign fifo_wdata = 1'b0;
    assign rsp_word   = rsp_words[0];
  end

  // Per-request word offsets, popped in request order.
  fifo_v3 #(
    .FALL_THROUGH(1'b0),
    .DATA_WIDTH  (FifoW),
    .DEPTH       (MaxOutstanding)
  ) i_off_fifo (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .flush_i(1'b0),
    .full_o (fifo_full),
    .empty_o(fifo_empty),
    .data_i (fifo_wdata),
    .push_i (push),
    .data_o (fifo_rdata),
    .pop_i  (pop)
  );

  // Outstanding and drop counters; a flush dooms everything older than this edge.
  always_comb begin
    cnt_d  = cnt_q + CntW'(push) - CntW'(pop);
    drop_d = drop_q - CntW'(discard);
    if (flush_i) drop_d = cnt_q - CntW'(pop);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q  <= '0;
      drop_q <= '0;
    end else begin
      cnt_q  <= cnt_d;
      drop_q <= drop_d;
    end
  end

  // Registered response stage; rdata holds between deliveries.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      instr_rvalid_o <= 1'b0;
      instr_err_o    <= 1'b0;
      instr_rdata_o  <= '0;
      spurious_o     <= 1'b0;
    end else begin
      instr_rvalid_o <= deliver;
      instr_err_o    <= deliver && cache_rsp_error_i;
      if (deliver) instr_rdata_o <= cache_rsp_error_i ? '0 : rsp_word;
      if (cache_rsp_valid_i && (cnt_q == '0)) spurious_o <= 1'b1;
    end
  end

`ifndef SYNTHESIS
  a_drop_le_cnt : assert property (@(posedge clk_i) disable iff (!rst_ni)
    drop_q <= cnt_q);
  a_fifo_empty : assert property (@(posedge clk_i) disable iff (!rst_ni)
    (cnt_q == '0) == fifo_empty);
  a_fifo_full : assert property (@(posedge clk_i) disable iff (!rst_ni)
    (cnt_q == CntW'(MaxOutstanding)) == fifo_full);
`endif

endmodule

// File: tb/tb_instr2cache_bridge.sv
// Randomized and directed bench for instr2cache_bridge against a queue-based model.
module tb_instr2cache_bridge;

  localparam int unsigned AW      = 32;
  localparam int unsigned DW      = 32;
  localparam int unsigned LW      = 128;
  localparam int unsigned MAX_OUT = 3;

  logic          clk_i = 1'b0;
  logic          rst_ni = 1'b1;
  logic          flush_i = 1'b0;
  logic          instr_req_i = 1'b0;
  logic [AW-1:0] instr_addr_i = '0;
  logic [1:0]    instr_memtype_i = '0;
  logic          instr_gnt_o, instr_rvalid_o, instr_err_o;
  logic [DW-1:0] instr_rdata_o;
  logic          cache_valid_o, cache_cacheable_o, spurious_o;
  logic          cache_ready_i = 1'b0;
  logic [AW-1:0] cache_addr_o;
  logic          cache_rsp_valid_i = 1'b0;
  logic [LW-1:0] cache_rsp_data_i = '0;
  logic          cache_rsp_error_i = 1'b0;

  always #5 clk_i = ~clk_i;

  instr2cache_bridge #(
    .AddrWidth(AW), .DataWidth(DW), .LineWidth(LW), .MaxOutstanding(MAX_OUT)
  ) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .flush_i(flush_i),
    .instr_req_i(instr_req_i), .instr_addr_i(instr_addr_i),
    .instr_memtype_i(instr_memtype_i), .instr_gnt_o(instr_gnt_o),
    .instr_rvalid_o(instr_rvalid_o), .instr_rdata_o(instr_rdata_o),
    .instr_err_o(instr_err_o), .cache_valid_o(cache_valid_o),
    .cache_ready_i(cache_ready_i), .cache_addr_o(cache_addr_o),
    .cache_cacheable_o(cache_cacheable_o), .cache_rsp_valid_i(cache_rsp_valid_i),
    .cache_rsp_data_i(cache_rsp_data_i), .cache_rsp_error_i(cache_rsp_error_i),
    .spurious_o(spurious_o)
  );

  // Model: each outstanding fetch remembers its word offset and whether a
  // flush has condemned it.
  typedef struct {
    int unsigned off;
    bit          killed;
  } fetch_t;

  fetch_t        mq[$];
  bit            e_rvalid, e_err, e_spur;
  logic [DW-1:0] e_rdata;
  int unsigned   n_cmp = 0;
  int unsigned   n_bad = 0;

  task automatic check_eq(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    e_rvalid = 0;
    e_err    = 0;
    e_spur   = 0;
    e_rdata  = '0;
  endtask

  task automatic set_idle();
    instr_req_i       = 1'b0;
    cache_rsp_valid_i = 1'b0;
    cache_rsp_error_i = 1'b0;
    flush_i           = 1'b0;
  endtask

  function automatic logic [LW-1:0] rand_line();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // One clock: check combinational request outputs mid-cycle, then advance the
  // model across the edge and check the registered outputs.
  task automatic step();
    bit          nf, e_gnt, pop;
    fetch_t      head;
    int unsigned killed;
    logic [AW-1:0] e_addr;
    @(negedge clk_i);
    nf     = (mq.size() < MAX_OUT);
    e_gnt  = instr_req_i && nf && cache_ready_i;
    e_addr = instr_addr_i & ~AW'(32'hF);
    check_eq("gnt", instr_gnt_o, e_gnt);
    check_eq("cache_valid", cache_valid_o, instr_req_i && nf);
    check_eq("cache_addr", cache_addr_o, e_addr);
    check_eq("cacheable", cache_cacheable_o, instr_memtype_i[1]);
    @(posedge clk_i);
    #1;
    pop = cache_rsp_valid_i && (mq.size() > 0);
    if (cache_rsp_valid_i && mq.size() == 0) e_spur = 1;
    e_rvalid = 0;
    e_err    = 0;
    if (pop) begin
      head = mq.pop_front();
      if (!head.killed) begin
        e_rvalid = 1;
        e_err    = cache_rsp_error_i;
        e_rdata  = cache_rsp_error_i ? '0 : cache_rsp_data_i[head.off*DW +: DW];
      end
    end
    if (flush_i) foreach (mq[i]) mq[i].killed = 1;
    if (e_gnt) mq.push_back('{off: int'(instr_addr_i[3:2]), killed: 0});
    killed = 0;
    foreach (mq[i]) if (mq[i].killed) killed++;
    check_eq("rvalid", instr_rvalid_o, e_rvalid);
    check_eq("err", instr_err_o, e_err);
    check_eq("rdata", instr_rdata_o, e_rdata);
    check_eq("spurious", spurious_o, e_spur);
    check_eq("drop", dut.drop_q, killed);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [LW-1:0] line;
    model_reset();
    #1 rst_ni = 1'b0;
    #3;
    check_eq("rst_rvalid", instr_rvalid_o, 1'b0);
    check_eq("rst_rdata", instr_rdata_o, '0);
    check_eq("rst_err", instr_err_o, 1'b0);
    check_eq("rst_spurious", spurious_o, 1'b0);
    check_eq("rst_drop", dut.drop_q, '0);
    @(posedge clk_i);
    #1 rst_ni = 1'b1;

    // Single fetch, word 2 of the line.
    instr_req_i = 1; instr_addr_i = 32'h1008; instr_memtype_i = 2'b10; cache_ready_i = 1;
    #1 check_eq("t1_addr", cache_addr_o, 32'h1000);
    step();
    instr_req_i = 0;
    cache_rsp_valid_i = 1;
    cache_rsp_data_i = 128'hDDDDDDDD_CCCCCCCC_BBBBBBBB_AAAAAAAA;
    step();
    check_eq("t1_rvalid", instr_rvalid_o, 1'b1);
    check_eq("t1_rdata", instr_rdata_o, 32'hCCCCCCCC);
    check_eq("t1_err", instr_err_o, 1'b0);
    cache_rsp_valid_i = 0;
    step();
    check_eq("t1_rvalid_low", instr_rvalid_o, 1'b0);

    // Cache backpressure for three cycles.
    instr_req_i = 1; instr_addr_i = 32'h2004; instr_memtype_i = 2'b00; cache_ready_i = 0;
    repeat (3) begin
      #1;
      check_eq("bp_gnt", instr_gnt_o, 1'b0);
      check_eq("bp_valid", cache_valid_o, 1'b1);
      step();
    end
    cache_ready_i = 1;
    #1 check_eq("bp_gnt4", instr_gnt_o, 1'b1);
    step();
    instr_req_i = 0;
    cache_rsp_valid_i = 1; cache_rsp_data_i = rand_line();
    step();
    cache_rsp_valid_i = 0;

    // Fill to the outstanding limit; no bypass on the popping cycle.
    instr_req_i = 1;
    for (int k = 0; k < int'(MAX_OUT); k++) begin
      instr_addr_i = 32'h3000 + 32'(4 * k);
      step();
    end
    instr_addr_i = 32'h3100;
    #1;
    check_eq("full_gnt", instr_gnt_o, 1'b0);
    check_eq("full_valid", cache_valid_o, 1'b0);
    step();
    cache_rsp_valid_i = 1; cache_rsp_data_i = rand_line();
    #1 check_eq("full_pop_gnt", instr_gnt_o, 1'b0);
    step();
    cache_rsp_valid_i = 0;
    #1 check_eq("after_pop_gnt", instr_gnt_o, 1'b1);
    step();
    instr_req_i = 0;
    for (int k = 0; k < 8 && mq.size() > 0; k++) begin
      cache_rsp_valid_i = 1; cache_rsp_data_i = rand_line();
      step();
    end
    cache_rsp_valid_i = 0;

    // Flush with two outstanding and a simultaneous new grant.
    instr_req_i = 1; instr_addr_i = 32'h100; step();
    instr_addr_i = 32'h104; step();
    instr_addr_i = 32'h200; flush_i = 1; step();
    flush_i = 0; instr_req_i = 0;
    check_eq("fl_drop2", dut.drop_q, 2);
    for (int k = 0; k < 2; k++) begin
      cache_rsp_valid_i = 1; cache_rsp_data_i = rand_line();
      step();
      check_eq("fl_dropped", instr_rvalid_o, 1'b0);
    end
    line = rand_line();
    cache_rsp_data_i = line;
    step();
    check_eq("fl_rvalid", instr_rvalid_o, 1'b1);
    check_eq("fl_rdata", instr_rdata_o, line[31:0]);
    check_eq("fl_drop0", dut.drop_q, 0);
    cache_rsp_valid_i = 0;

    // Error response followed by a good one.
    instr_req_i = 1; instr_addr_i = 32'h408; step();
    instr_req_i = 0;
    cache_rsp_valid_i = 1; cache_rsp_error_i = 1; cache_rsp_data_i = rand_line();
    step();
    check_eq("er_rvalid", instr_rvalid_o, 1'b1);
    check_eq("er_err", instr_err_o, 1'b1);
    check_eq("er_rdata", instr_rdata_o, '0);
    cache_rsp_valid_i = 0; cache_rsp_error_i = 0;
    instr_req_i = 1; instr_addr_i = 32'h40C; step();
    instr_req_i = 0;
    line = rand_line();
    cache_rsp_valid_i = 1; cache_rsp_data_i = line;
    step();
    check_eq("ok_err", instr_err_o, 1'b0);
    check_eq("ok_rdata", instr_rdata_o, line[127:96]);
    cache_rsp_valid_i = 0;

    // Randomized traffic.
    for (int c = 0; c < 1500; c++) begin
      instr_req_i       = ($urandom_range(99) < 70);
      instr_addr_i      = $urandom & ~32'h3;
      instr_memtype_i   = 2'($urandom);
      cache_ready_i     = ($urandom_range(99) < 70);
      cache_rsp_valid_i = (mq.size() > 0) && ($urandom_range(99) < 45);
      cache_rsp_error_i = ($urandom_range(99) < 15);
      cache_rsp_data_i  = rand_line();
      flush_i           = ($urandom_range(99) < 5);
      step();
    end
    set_idle();
    for (int k = 0; k < 8 && mq.size() > 0; k++) begin
      cache_rsp_valid_i = 1; cache_rsp_data_i = rand_line();
      step();
    end
    set_idle();
    step();

    // Spurious response is sticky.
    cache_rsp_valid_i = 1; cache_rsp_data_i = rand_line();
    step();
    check_eq("sp_set", spurious_o, 1'b1);
    cache_rsp_valid_i = 0;
    repeat (3) step();
    check_eq("sp_sticky", spurious_o, 1'b1);

    // Asynchronous reset in the middle of a burst.
    cache_ready_i = 1;
    instr_req_i = 1; instr_addr_i = 32'h504; step();
    instr_addr_i = 32'h508;
    cache_rsp_valid_i = 1; cache_rsp_data_i = {4{32'h5A5A_0001}};
    step();
    check_eq("mr_rvalid_pre", instr_rvalid_o, 1'b1);
    #2 rst_ni = 1'b0;
    #1;
    check_eq("mr_rvalid", instr_rvalid_o, 1'b0);
    check_eq("mr_rdata", instr_rdata_o, '0);
    check_eq("mr_err", instr_err_o, 1'b0);
    check_eq("mr_spurious", spurious_o, 1'b0);
    model_reset();
    set_idle();
    @(posedge clk_i);
    #1 rst_ni = 1'b1;
    cache_rsp_valid_i = 1; cache_rsp_data_i = rand_line();
    step();
    check_eq("mr_post_spurious", spurious_o, 1'b1);
    set_idle();
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
